// File: rtl/window_3x3_linebuf_if.sv
// window_3x3_linebuf_if: raster pixel stream in, registered 3x3 window stream out.
interface window_3x3_linebuf_if #(
    parameter int DATA_W = 17,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
);
    logic                     in_valid;
    logic                     in_sof;
    logic [DATA_W-1:0]        in_pixel;
    logic [DATA_W-1:0]        p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic                     out_valid;
    logic [$clog2(IMG_W)-1:0] out_x;
    logic [$clog2(IMG_H)-1:0] out_y;
    logic                     frame_done;
    modport master (
        output in_valid, in_sof, in_pixel,
        input  p0, p1, p2, p3, p4, p5, p6, p7, p8, out_valid, out_x, out_y, frame_done
    );
    modport slave (
        input  in_valid, in_sof, in_pixel,
        output p0, p1, p2, p3, p4, p5, p6, p7, p8, out_valid, out_x, out_y, frame_done
    );
endinterface

// File: rtl/window_3x3_linebuf.sv
// window_3x3_linebuf: two line buffers feed a shifting 3x3 register window; one window per accepted pixel.
module window_3x3_linebuf #(
    parameter int DATA_W = 17,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    window_3x3_linebuf_if.slave  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    logic [XW-1:0]     x_q, x_d, xc, ox_q;
    logic [YW-1:0]     y_q, y_d, yc, oy_q;
    logic              last_x, last_y, ov_q, fd_q;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    // in_sof forces the accepted pixel to (0,0) whatever the counters say
    always_comb begin
        xc     = bus.in_sof ? '0 : x_q;
        yc     = bus.in_sof ? '0 : y_q;
        last_x = xc == XW'(IMG_W - 1);
        last_y = yc == YW'(IMG_H - 1);
        x_d    = last_x ? '0 : xc + 1'b1;
        y_d    = last_x ? (last_y ? '0 : yc + 1'b1) : yc;
        win_d  = '{win_q[1], win_q[2], lb2[xc],
                   win_q[4], win_q[5], lb1[xc],
                   win_q[7], win_q[8], bus.in_pixel};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            win_q <= '{default: '0};
            ov_q  <= 1'b0;
            fd_q  <= 1'b0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            ov_q <= bus.in_valid && xc >= XW'(2) && yc >= YW'(2);
            fd_q <= bus.in_valid && last_x && last_y;
            if (bus.in_valid) begin
                x_q   <= x_d;
                y_q   <= y_d;
                win_q <= win_d;
                ox_q  <= xc - 1'b1;
                oy_q  <= yc - 1'b1;
            end
        end
    end
    // line storage is never reset; the x>=2, y>=2 gate keeps stale rows out of valid windows
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb1[xc] <= bus.in_pixel;
            lb2[xc] <= lb1[xc];
        end
    end
    assign bus.p0         = win_q[0];
    assign bus.p1         = win_q[1];
    assign bus.p2         = win_q[2];
    assign bus.p3         = win_q[3];
    assign bus.p4         = win_q[4];
    assign bus.p5         = win_q[5];
    assign bus.p6         = win_q[6];
    assign bus.p7         = win_q[7];
    assign bus.p8         = win_q[8];
    assign bus.out_valid  = ov_q;
    assign bus.out_x      = ox_q;
    assign bus.out_y      = oy_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_window_3x3_linebuf.sv
// tb_window_3x3_linebuf: directed streams with a queue scoreboard built from a per-frame pixel pattern.
module tb_window_3x3_linebuf;
    localparam int DW = 17;
    localparam int W  = 256;
    localparam int H  = 256;
    typedef struct packed {
        logic [8:0][DW-1:0] p;
        logic [7:0]         x;
        logic [7:0]         y;
        logic               fd;
    } win_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    window_3x3_linebuf_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();
    window_3x3_linebuf #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));
    win_t          q[$];
    int            checks = 0, failures = 0, mx = 0, my = 0, nwin = 0;
    logic [DW-1:0] seed;
    function automatic logic [DW-1:0] pix(input int x, input int y);
        return DW'(y * W + x) ^ seed;
    endfunction
    function automatic win_t obs();
        win_t w;
        w.p  = {bus.p8, bus.p7, bus.p6, bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0};
        w.x  = bus.out_x;
        w.y  = bus.out_y;
        w.fd = bus.frame_done;
        return w;
    endfunction
    task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        win_t prev, e;
        prev = obs();
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = d;
        if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            if (mx >= 2 && my >= 2) begin
                for (int i = 0; i < 9; i++) e.p[i] = pix(mx - 2 + i % 3, my - 2 + i / 3);
                e.x  = 8'(mx - 1);
                e.y  = 8'(my - 1);
                e.fd = (mx == W - 1 && my == H - 1);
                q.push_back(e);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else mx++;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 192'(bus.out_valid), 192'(q.size() != 0));
        if (q.size() != 0) begin
            if (bus.out_valid) nwin++;
            chk("window", 192'(obs()), 192'(q.pop_front()));
        end else chk("idle_frame_done", 192'(bus.frame_done), 192'(0));
        if (!v) chk("hold", 192'(obs().p), 192'(prev.p));
    endtask
    task automatic px(input logic s);
        int ex, ey;
        ex = s ? 0 : mx;
        ey = s ? 0 : my;
        step(1'b1, s, pix(ex, ey));
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        seed         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 192'(obs()), 192'(0));
        chk("reset_valid", 192'(bus.out_valid), 192'(0));
        rst = 1'b0;
        // full continuous frame
        for (int i = 0; i < W * H; i++) begin
            px(i == 0);
            if (i == 2 * W + 2) begin
                chk("first_window", 192'({bus.p0, bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8}),
                    192'({17'd0, 17'd1, 17'd2, 17'd256, 17'd257, 17'd258, 17'd512, 17'd513, 17'd514}));
                chk("first_xy", 192'({bus.out_valid, bus.out_x, bus.out_y}), 192'({1'b1, 8'd1, 8'd1}));
            end
        end
        chk("window_count", 192'(nwin), 192'(64516));
        chk("last_p4", 192'(bus.p4), 192'(65278));
        chk("last_xy_fd", 192'({bus.out_x, bus.out_y, bus.frame_done}), 192'({8'd254, 8'd254, 1'b1}));
        step(1'b0, 1'b0, '0);
        // gapped input, including the no-window positions at row/line starts
        nwin = 0;
        for (int i = 0; i < 2 * W + 10; i++) begin
            px(i == 0);
            if (i == 2 * W + 2) chk("gap_first_valid", 192'(bus.out_valid), 192'(1));
            step(1'b0, 1'b0, DW'($urandom));
        end
        chk("gap_window_count", 192'(nwin), 192'(8));
        // reset mid-frame after (100,50)
        for (int i = 0; i < 50 * W + 101; i++) px(i == 0);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_reset", 192'({obs(), bus.out_valid}), 192'(0));
        @(posedge clk);
        #1;
        chk("held_reset", 192'({obs(), bus.out_valid}), 192'(0));
        rst = 1'b0;
        mx = 0;
        my = 0;
        q.delete();
        seed = 17'h1ABCD;
        nwin = 0;
        for (int i = 0; i < 10 * W + 11; i++) begin
            px(i == 0);
            if (i == 2 * W + 2) chk("post_reset_p4", 192'({bus.out_valid, bus.p4}), 192'({1'b1, pix(1, 1)}));
        end
        chk("post_reset_count", 192'(nwin), 192'(8 * (W - 2) + 9));
        // restart frame mid-stream at old (10,10)
        seed = 17'h0F0F0;
        nwin = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            px(i == 0);
            if (i == 2 * W + 2) chk("sof_restart_p4", 192'({bus.out_valid, bus.p4}), 192'({1'b1, pix(1, 1)}));
        end
        chk("sof_restart_count", 192'(nwin), 192'(2));
        step(1'b0, 1'b0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_3x3_linebuf.md
WINDOW_3X3_LINEBUF -- requirements
Module: window_3x3_linebuf

Interface
- REQ-001: Parameter DATA_W, default 17: pixel width in bits, matching the 3x3 kernel inputs.
- REQ-002: Parameter IMG_W, default 256: pixels per line.
- REQ-003: Parameter IMG_H, default 256: lines per frame.
- REQ-004: Port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-005: Port rst, input, 1: asynchronous, active-high reset.
- REQ-006: Port in_valid, input, 1: in_pixel is accepted this cycle; no backpressure exists.
- REQ-007: Port in_sof, input, 1: start of frame; qualified by in_valid; marks pixel (0,0).
- REQ-008: Port in_pixel, input, DATA_W: pixel value in raster order.
- REQ-009: Ports p0..p8, output, DATA_W each: 3x3 window, registered, row-major (p0 top-left, p4 centre, p8 bottom-right).
- REQ-010: Port out_valid, output, 1: p0..p8 hold a new valid window this cycle (one-cycle pulse per window).
- REQ-011: Port out_x, output, 8: column of the window centre p4 (clog2(IMG_W) bits in general).
- REQ-012: Port out_y, output, 8: row of the window centre p4.
- REQ-013: Port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
- REQ-014: Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) SHALL give the position of the pixel being accepted; both advance only on in_valid.
- REQ-015: On acceptance, x SHALL increment; at x=IMG_W-1 it SHALL wrap to 0 and y SHALL increment; at (IMG_W-1, IMG_H-1) both SHALL wrap to 0.
- REQ-016: in_valid with in_sof SHALL treat the pixel as (0,0) regardless of counter state; following pixels continue from (1,0).
- REQ-017: Two line buffers of IMG_W x DATA_W SHALL hold rows y-1 and y-2; accepting (x,y) SHALL read both at column x and then write in_pixel into row y-1 storage and the old row y-1 value into row y-2 storage.
- REQ-018: A 3x3 register window SHALL shift left one column on each accepted pixel; new right column = {row y-2 [x], row y-1 [x], in_pixel} into {p2, p5, p8}.
- REQ-019: The window SHALL not shift on cycles with in_valid=0; p0..p8 SHALL hold.
- REQ-020: out_valid SHALL assert exactly one cycle after accepting (x,y) with x>=2 and y>=2; out_x=x-1, out_y=y-1 in that cycle.
- REQ-021: Windows straddling a line wrap (x<2) or within the first two rows (y<2) SHALL never assert out_valid; each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
- REQ-022: frame_done SHALL pulse one cycle after accepting (IMG_W-1, IMG_H-1), coincident with the final out_valid.
- REQ-023: Latency in_valid to out_valid SHALL be exactly 1 cycle; back-to-back input SHALL sustain one window per cycle.
- REQ-024: Pixel data SHALL pass unmodified; no arithmetic on pixel values, full DATA_W preserved.
- REQ-025: in_sof asserted mid-frame SHALL abandon the partial frame; first output after it obeys REQ-020/021 counted from the new (0,0).

Reset
- REQ-026: rst high SHALL asynchronously clear x, y, p0..p8, out_valid, out_x, out_y, frame_done to 0.
- REQ-027: Line buffer contents SHALL not be cleared; REQ-021 guarantees stale data never reaches an asserted out_valid.
- REQ-028: Reset mid-frame SHALL restart counting at (0,0) with the next accepted pixel.

Verification
- REQ-029: Stream 256x256 frame, pixel = y*256+x, in_valid always high -> first out_valid one cycle after pixel (2,2): p0..p8 = 0,1,2,256,257,258,512,513,514; out_x=1, out_y=1.
- REQ-030: Same frame -> exactly 64516 out_valid pulses; last window p4=65278 (out_x=254, out_y=254) with frame_done in the same cycle.
- REQ-031: Same frame with in_valid toggling 1,0,1,0 -> identical window sequence; no out_valid on idle cycles; p0..p8 held.
- REQ-032: Accept pixels (0,1),(1,1),(255,1),(0,2),(1,2) -> no out_valid; pixel (2,2) -> out_valid next cycle.
- REQ-033: rst pulse after pixel (100,50), then new frame with in_sof -> outputs zero during reset; first out_valid after new (2,2) with correct new-frame values.
- REQ-034: in_sof mid-frame at old (10,10) -> no out_valid until new (2,2) accepted; window matches new-frame data.
